decoder_proj_formal: RTL and testbench
======================================

Name: decoder_proj_formal

Overview:
Registered 4-bit code decoder driven from the 7-bit user I/O input bus (io_in).
- Captures a nibble on a load strobe.
- Produces a one-hot 16-line decode, a hex 7-segment pattern, a valid flag and a BCD-range error flag.
- Sits behind the user-project pad wrapper; also serves as the top for formal cover runs, where io_in is the only free input.

Parameters:
SEG_RESET, 7'h00, segment register value after reset (active-high pattern, before polarity inversion)

Ports:
wb_clk_i  input  1  system clock, rising edge
wb_rst_i  input  1  asynchronous reset, active-high
io_in  input  7  [3:0] code, [4] load, [5] seg_pol (1 = active-low segments), [6] blank
onehot_o  output  16  one-hot decode of the held code
seg_o  output  7  segments {g,f,e,d,c,b,a}, bit0 = a
valid_o  output  1  a code has been loaded since reset
bcd_err_o  output  1  held code > 9

Behaviour:
- Reset (async assert, sync release): code register = 0, valid register = 0, segment register = SEG_RESET.
  - Outputs during reset: onehot_o = 0, seg_o = SEG_RESET (after the polarity rule below), valid_o = 0, bcd_err_o = 0.
- Load: on a rising clock edge with io_in[4] = 1, code register <= io_in[3:0] and valid register <= 1.
  - Latency is 1 cycle: outputs reflect the new code from the edge that samples load.
  - Back-to-back loads on consecutive cycles each update the register; the last one wins.
- No load: the code and valid registers hold.
- Outputs are combinational from the registers and the live io_in[6:5]; blank and polarity take effect with 0-cycle latency.
- onehot_o = (valid & ~blank) ? (1 << code) : 16'h0000.
- Hex segment table (active-high, gfedcba):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Raw pattern:
  - 7'h00 when blank = 1 or valid = 0;
  - otherwise the table entry for code.
- seg_o = seg_pol ? ~raw : raw. Blank with seg_pol = 1 therefore gives 7'h7F.
- bcd_err_o = valid & (code > 9). It is independent of blank.
- Reset mid-operation clears immediately, asynchronously to the clock; a load asserted during reset is ignored.
- Simultaneous load and blank: the code is still captured; only the outputs are blanked.
- No X propagation: all registers have reset values.

Optional Feature:
DECODER_LOAD_CNT_EN
- Defined:
  - Adds output load_cnt_o[7:0], a count of accepted loads.
  - Reset value 0; increments by 1 on each clock edge where io_in[4] = 1.
  - Wraps from 255 to 0.
  - Not affected by blank.
- Undefined: neither the port nor the counter exists; all other behaviour is identical.

Test Plan:
- Reset asserted, io_in = 7'b1110011 -> onehot_o = 0, valid_o = 0, bcd_err_o = 0, seg_o = 7'h7F (SEG_RESET 0 inverted by seg_pol = 1). Reset released, one edge -> code = 3, valid_o = 1, onehot_o still 0 and seg_o still 7'h7F (blanked).
- Drop blank, io_in = 7'b0010011, one edge -> onehot_o = 16'h0008, seg_o = 7'h4F, bcd_err_o = 0.
- io_in = 7'b0011011 (code B), one edge -> onehot_o = 16'h0800, seg_o = 7'h7C, bcd_err_o = 1. Then io_in = 7'b0100000 (no load, seg_pol = 1) -> code held, seg_o = 7'h03 with 0-cycle latency.
- Sweep codes 0..15 with load each cycle -> onehot_o = 1 << code and seg_o matches the table every cycle after the sampling edge; bcd_err_o = 1 only for codes 10..15.
- Assert wb_rst_i between clock edges while valid -> all outputs return to reset values before the next edge; a load held high during reset is not captured.
- With DECODER_LOAD_CNT_EN: 256 consecutive loads -> load_cnt_o wraps to 0; a load with blank = 1 still increments.

Source files
------------

// File: rtl/decoder_proj_formal.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_proj_formal
//  Description : Registered 4-bit code decoder fed from the 7-bit user I/O
//                bus. A nibble is captured on the load strobe and decoded
//                into a one-hot 16-line bus, a hex 7-segment pattern, a
//                valid flag and a BCD-range error flag. Blank and segment
//                polarity act combinationally on the registered state.
//  Options     : DECODER_LOAD_CNT_EN - adds load_cnt_o, an 8-bit wrapping
//                count of accepted loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_proj_formal #(
   parameter logic [6:0] SEG_RESET = 7'h00
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [6:0]  io_in,
   output logic [15:0] onehot_o,
   output logic [6:0]  seg_o,
   output logic        valid_o,
   output logic        bcd_err_o
`ifdef DECODER_LOAD_CNT_EN
   ,
   output logic [7:0]  load_cnt_o
`endif
);

   // io_in field breakout
   logic [3:0] w_code_in;
   logic       w_load;
   logic       w_seg_pol;
   logic       w_blank;

   assign w_code_in = io_in[3:0];
   assign w_load    = io_in[4];
   assign w_seg_pol = io_in[5];
   assign w_blank   = io_in[6];

   // Held state
   logic [3:0] r_code;
   logic       r_valid;
   logic [6:0] r_seg;

   // Segment pattern for the incoming code; registered alongside the code so
   // the output path carries no table lookup after the flop.
   logic [6:0] w_seg_next;

   // Hex 7-segment lookup, active-high, {g,f,e,d,c,b,a}
   always_comb begin
      w_seg_next = 7'h00;
      case (w_code_in)
         4'h0: w_seg_next = 7'h3F;
         4'h1: w_seg_next = 7'h06;
         4'h2: w_seg_next = 7'h5B;
         4'h3: w_seg_next = 7'h4F;
         4'h4: w_seg_next = 7'h66;
         4'h5: w_seg_next = 7'h6D;
         4'h6: w_seg_next = 7'h7D;
         4'h7: w_seg_next = 7'h07;
         4'h8: w_seg_next = 7'h7F;
         4'h9: w_seg_next = 7'h6F;
         4'hA: w_seg_next = 7'h77;
         4'hB: w_seg_next = 7'h7C;
         4'hC: w_seg_next = 7'h39;
         4'hD: w_seg_next = 7'h5E;
         4'hE: w_seg_next = 7'h79;
         4'hF: w_seg_next = 7'h71;
         default: w_seg_next = 7'h00;
      endcase
   end

   // Capture code, its segment pattern and the valid flag on each load strobe
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_code  <= 4'h0;
         r_valid <= 1'b0;
         r_seg   <= SEG_RESET;
      end else if (w_load) begin
         r_code  <= w_code_in;
         r_valid <= 1'b1;
         r_seg   <= w_seg_next;
      end
   end

`ifdef DECODER_LOAD_CNT_EN
   logic [7:0] r_load_cnt;

   // Count every accepted load; wraps naturally at 8 bits, blank has no effect
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_load_cnt <= 8'h00;
      end else if (w_load) begin
         r_load_cnt <= r_load_cnt + 8'h01;
      end
   end

   assign load_cnt_o = r_load_cnt;
`endif

   // Before the first load r_seg still holds SEG_RESET, so the segment path
   // shows the reset pattern until valid without an extra valid gate.
   logic [6:0] w_seg_raw;

   // Output decode: blank and polarity act with zero latency on live io_in
   always_comb begin
      w_seg_raw = w_blank ? 7'h00 : r_seg;
      seg_o     = w_seg_pol ? ~w_seg_raw : w_seg_raw;
      onehot_o  = (r_valid && !w_blank) ? (16'h0001 << r_code) : 16'h0000;
      valid_o   = r_valid;
      bcd_err_o = r_valid && (r_code > 4'd9);
   end

endmodule
`default_nettype wire

// File: tb/tb_decoder_proj_formal.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_proj_formal
//  Description : Self-checking bench for decoder_proj_formal. Expected output
//                tuples come from an independent reference model and are
//                queued when stimulus is applied, then popped and compared
//                once the DUT has sampled it. Build with
//                DECODER_LOAD_CNT_EN to also exercise the load counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_proj_formal;

   typedef struct packed {
      logic [15:0] oh;
      logic [6:0]  seg;
      logic        v;
      logic        e;
   } out_t;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic [6:0]  io_in;
   logic [15:0] onehot_o;
   logic [6:0]  seg_o;
   logic        valid_o;
   logic        bcd_err_o;
`ifdef DECODER_LOAD_CNT_EN
   logic [7:0]  load_cnt_o;
`endif

   decoder_proj_formal dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .io_in     (io_in),
      .onehot_o  (onehot_o),
      .seg_o     (seg_o),
      .valid_o   (valid_o),
      .bcd_err_o (bcd_err_o)
`ifdef DECODER_LOAD_CNT_EN
      ,
      .load_cnt_o(load_cnt_o)
`endif
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int   vectors     = 0;
   int   miscompares = 0;
   out_t sb[$];

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference model state
   logic [3:0] m_code  = 4'h0;
   logic       m_valid = 1'b0;
   logic [7:0] m_cnt   = 8'h00;

   function automatic out_t model_out(input logic [6:0] io);
      out_t       r;
      logic [6:0] raw;
      raw   = (io[6] || !m_valid) ? 7'h00 : seg_tab[m_code];
      r.oh  = (m_valid && !io[6]) ? (16'h0001 << m_code) : 16'h0000;
      r.seg = io[5] ? ~raw : raw;
      r.v   = m_valid;
      r.e   = m_valid && (m_code > 4'd9);
      return r;
   endfunction

   function automatic out_t dut_out();
      return {onehot_o, seg_o, valid_o, bcd_err_o};
   endfunction

   // Apply io for one clock edge (called just after an edge), advance the
   // model, queue the expected post-edge outputs.
   task automatic drive_cycle(input logic [6:0] io);
      io_in = io;
      if (io[4]) begin
         m_code  = io[3:0];
         m_valid = 1'b1;
         m_cnt   = m_cnt + 8'h01;
      end
      sb.push_back(model_out(io));
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic model_reset();
      m_code  = 4'h0;
      m_valid = 1'b0;
      m_cnt   = 8'h00;
      sb.delete();
   endtask

   task automatic test_reset();
      out_t ex, ob;
      wb_rst_i = 1'b1;
      io_in    = 7'b1110011;
      model_reset();
      #2;
      ex = '{oh: 16'h0000, seg: 7'h7F, v: 1'b0, e: 1'b0};
      ob = dut_out();
      vectors++;
      if (ob !== ex) begin
         miscompares++;
         $display("FAIL reset_state: got %h, expected %h", ob, ex);
      end
      // a load strobe seen at an edge while reset is held is ignored
      @(posedge wb_clk_i);
      #1;
      ob = dut_out();
      vectors++;
      if (ob !== ex) begin
         miscompares++;
         $display("FAIL reset_load_ignored: got %h, expected %h", ob, ex);
      end
      wb_rst_i = 1'b0;
      drive_cycle(7'b1110011);
      ex = sb.pop_front();
      ob = dut_out();
      vectors++;
      if (ob !== ex || ob !== out_t'({16'h0000, 7'h7F, 1'b1, 1'b0})) begin
         miscompares++;
         $display("FAIL first_load_blanked: got %h, expected %h", ob, ex);
      end
   endtask

   task automatic test_decode();
      out_t ex, ob;
      drive_cycle(7'b0010011);
      ex = sb.pop_front();
      ob = dut_out();
      vectors++;
      if (ob !== ex || ob !== out_t'({16'h0008, 7'h4F, 1'b1, 1'b0})) begin
         miscompares++;
         $display("FAIL decode_3: got %h, expected %h", ob, ex);
      end
   endtask

   task automatic test_hold_polarity();
      out_t ex, ob;
      drive_cycle(7'b0011011);
      ex = sb.pop_front();
      ob = dut_out();
      vectors++;
      if (ob !== ex || ob !== out_t'({16'h0800, 7'h7C, 1'b1, 1'b1})) begin
         miscompares++;
         $display("FAIL decode_B: got %h, expected %h", ob, ex);
      end
      // polarity change with no clock edge
      io_in = 7'b0100000;
      #1;
      ex = '{oh: 16'h0800, seg: 7'h03, v: 1'b1, e: 1'b1};
      ob = dut_out();
      vectors++;
      if (ob !== ex) begin
         miscompares++;
         $display("FAIL polarity_zero_latency: got %h, expected %h", ob, ex);
      end
      // code holds across an edge with no load
      drive_cycle(7'b0100000);
      ex = sb.pop_front();
      ob = dut_out();
      vectors++;
      if (ob !== ex) begin
         miscompares++;
         $display("FAIL hold_no_load: got %h, expected %h", ob, ex);
      end
   endtask

   task automatic test_sweep();
      out_t ex, ob;
      for (int i = 0; i < 16; i++) begin
         drive_cycle({3'b001, 4'(i)});
         ex = sb.pop_front();
         ob = dut_out();
         vectors++;
         if (ob !== ex) begin
            miscompares++;
            $display("FAIL sweep code=%0d: got %h, expected %h", i, ob, ex);
         end
      end
   endtask

   task automatic test_back_to_back();
      out_t ex, ob;
      logic [6:0] seq [4] = '{7'b0010101, 7'b0011001, 7'b1010110, 7'b0000000};
      for (int i = 0; i < 4; i++) begin
         drive_cycle(seq[i]);
         ex = sb.pop_front();
         ob = dut_out();
         vectors++;
         if (ob !== ex) begin
            miscompares++;
            $display("FAIL back_to_back step=%0d: got %h, expected %h", i, ob, ex);
         end
      end
      // load taken under blank must show once blank drops
      if (seg_o !== 7'h7D) begin
         miscompares++;
         $display("FAIL load_under_blank: got seg %h, expected 7d", seg_o);
      end
      vectors++;
   endtask

   task automatic test_async_reset();
      out_t ex, ob;
      io_in = 7'b0010111;
      #2;
      wb_rst_i = 1'b1;
      model_reset();
      #1;
      ex = '{oh: 16'h0000, seg: 7'h00, v: 1'b0, e: 1'b0};
      ob = dut_out();
      vectors++;
      if (ob !== ex) begin
         miscompares++;
         $display("FAIL async_reset_immediate: got %h, expected %h", ob, ex);
      end
      @(posedge wb_clk_i);
      #1;
      ob = dut_out();
      vectors++;
      if (ob !== ex) begin
         miscompares++;
         $display("FAIL async_reset_load_ignored: got %h, expected %h", ob, ex);
      end
      wb_rst_i = 1'b0;
      drive_cycle(7'b0000000);
      ex = sb.pop_front();
      ob = dut_out();
      vectors++;
      if (ob !== ex) begin
         miscompares++;
         $display("FAIL post_reset_no_load: got %h, expected %h", ob, ex);
      end
   endtask

`ifdef DECODER_LOAD_CNT_EN
   task automatic test_load_cnt();
      out_t ex, ob;
      for (int i = 0; i < 256; i++) begin
         drive_cycle({(i % 3 == 0) ? 1'b1 : 1'b0, 2'b01, 4'(i)});
         ex = sb.pop_front();
         ob = dut_out();
         vectors++;
         if (ob !== ex || load_cnt_o !== m_cnt) begin
            miscompares++;
            $display("FAIL load_cnt i=%0d: got %h cnt=%0d, expected %h cnt=%0d",
                     i, ob, load_cnt_o, ex, m_cnt);
         end
      end
      vectors++;
      if (load_cnt_o !== 8'h00) begin
         miscompares++;
         $display("FAIL load_cnt_wrap: got %0d, expected 0", load_cnt_o);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_decode();
      test_hold_polarity();
      test_sweep();
      test_back_to_back();
      test_async_reset();
`ifdef DECODER_LOAD_CNT_EN
      test_load_cnt();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
